// File: rtl/change_dispenser.sv
// Greedy 25/10/5 coin payout to a hopper, one coin per ack, skipping empty tubes; faults with the unpaid shortfall.
// Latency: start -> SELECT next cycle, 2 cycles per immediately-acked coin; hopper stalls bounded by TIMEOUT.
module change_dispenser #(
    parameter int BITS    = 6,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [BITS-1:0] amount,
    input  logic            empty25,
    input  logic            empty10,
    input  logic            empty5,
    input  logic            hopper_ack,
    input  logic            fault_clr,
    output logic            d25,
    output logic            d10,
    output logic            d5,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [BITS-1:0] remaining,
    output logic [BITS-1:0] shortfall
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DISPENSE,
        DONE,
        FAULT
    } state_t;

    localparam logic [BITS-1:0] C25  = BITS'(25);
    localparam logic [BITS-1:0] C10  = BITS'(10);
    localparam logic [BITS-1:0] C5   = BITS'(5);
    localparam logic [7:0]      TMAX = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] short_q, short_d;
    logic            d25_q, d25_d;
    logic            d10_q, d10_d;
    logic            d5_q, d5_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic [BITS-1:0] coin;

    // Only one request register is ever set, so it encodes the coin in flight.
    assign coin = d25_q ? C25 : (d10_q ? C10 : C5);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        short_d = short_q;
        d25_d   = d25_q;
        d10_d   = d10_q;
        d5_d    = d5_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (rem_q >= C25 && !empty25) begin
                    d25_d   = 1'b1;
                    tcnt_d  = 8'd0;
                    state_d = DISPENSE;
                end else if (rem_q >= C10 && !empty10) begin
                    d10_d   = 1'b1;
                    tcnt_d  = 8'd0;
                    state_d = DISPENSE;
                end else if (rem_q >= C5 && !empty5) begin
                    d5_d    = 1'b1;
                    tcnt_d  = 8'd0;
                    state_d = DISPENSE;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    short_d = rem_q;
                    state_d = FAULT;
                end
            end
            DISPENSE: begin
                // Ack is checked first so a coin landing on the expiry edge still counts.
                if (hopper_ack) begin
                    rem_d   = rem_q - coin;
                    d25_d   = 1'b0;
                    d10_d   = 1'b0;
                    d5_d    = 1'b0;
                    state_d = SELECT;
                end else if (tcnt_q == TMAX) begin
                    d25_d   = 1'b0;
                    d10_d   = 1'b0;
                    d5_d    = 1'b0;
                    short_d = rem_q;
                    state_d = FAULT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    short_d = '0;
                    rem_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            short_q <= '0;
            d25_q   <= 1'b0;
            d10_q   <= 1'b0;
            d5_q    <= 1'b0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            d25_q   <= d25_d;
            d10_q   <= d10_d;
            d5_q    <= d5_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign d25       = d25_q;
    assign d10       = d10_q;
    assign d5        = d5_q;
    assign busy      = (state_q == SELECT) || (state_q == DISPENSE);
    assign done      = (state_q == DONE);
    assign fault     = (state_q == FAULT);
    assign remaining = rem_q;
    assign shortfall = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with TIMEOUT=8; expectations are hand-computed per edge.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [5:0] amount;
    logic       empty25, empty10, empty5;
    logic       hopper_ack;
    logic       fault_clr;
    logic       d25, d10, d5, busy, done, fault;
    logic [5:0] remaining, shortfall;

    int vectors = 0;
    int miscompares = 0;

    change_dispenser #(.BITS(6), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .amount    (amount),
        .empty25   (empty25),
        .empty10   (empty10),
        .empty5    (empty5),
        .hopper_ack(hopper_ack),
        .fault_clr (fault_clr),
        .d25       (d25),
        .d10       (d10),
        .d5        (d5),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .remaining (remaining),
        .shortfall (shortfall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {d25,d10,d5,busy,done,fault} for compact output checks.
    function automatic int outs();
        return {26'd0, d25, d10, d5, busy, done, fault};
    endfunction

    initial begin
        reset_n = 1'b0; start = 1'b0; amount = '0;
        empty25 = 1'b0; empty10 = 1'b0; empty5 = 1'b0;
        hopper_ack = 1'b0; fault_clr = 1'b0;
        #12;
        chk("reset_outs", outs(), 0);
        chk("reset_rem", int'(remaining), 0);
        chk("reset_short", int'(shortfall), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_outs", outs(), 0);

        // Greedy 40 = 25+10+5; ack held high throughout, fault_clr held high (ignored).
        hopper_ack = 1'b1; fault_clr = 1'b1;
        start = 1'b1; amount = 6'd40;
        tick();
        start = 1'b0;
        chk("g40_select_outs", outs(), 6'b000100);
        chk("g40_select_rem", int'(remaining), 40);
        tick();
        start = 1'b1; amount = 6'd50;      // ignored while busy
        chk("g40_d25_outs", outs(), 6'b100100);
        tick();
        chk("g40_rem15", int'(remaining), 15);
        chk("g40_sel2_outs", outs(), 6'b000100);
        tick();
        chk("g40_d10_outs", outs(), 6'b010100);
        start = 1'b0;
        tick();
        chk("g40_rem5", int'(remaining), 5);
        tick();
        chk("g40_d5_outs", outs(), 6'b001100);
        tick();
        chk("g40_rem0", int'(remaining), 0);
        chk("g40_sel4_outs", outs(), 6'b000100);
        tick();
        chk("g40_done_outs", outs(), 6'b000010);
        tick();
        chk("g40_idle_outs", outs(), 0);
        fault_clr = 1'b0;

        // 30 with the 25 tube empty: three 10s.
        empty25 = 1'b1;
        start = 1'b1; amount = 6'd30;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("e25_d10_%0d", i), outs(), 6'b010100);
            tick();
            chk($sformatf("e25_rem_%0d", i), int'(remaining), 20 - 10 * i);
        end
        tick();
        chk("e25_done_outs", outs(), 6'b000010);
        empty25 = 1'b0;
        tick();

        // 7 cents: one 5, then fault with shortfall 2.
        start = 1'b1; amount = 6'd7;
        tick();
        start = 1'b0;
        tick();
        chk("m7_d5_outs", outs(), 6'b001100);
        tick();
        chk("m7_rem2", int'(remaining), 2);
        tick();
        chk("m7_fault_outs", outs(), 6'b000001);
        chk("m7_short", int'(shortfall), 2);
        empty5 = 1'b1; empty10 = 1'b1;
        tick();
        chk("m7_fault_hold", outs(), 6'b000001);
        chk("m7_short_hold", int'(shortfall), 2);
        empty5 = 1'b0; empty10 = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("m7_clr_outs", outs(), 0);
        chk("m7_clr_short", int'(shortfall), 0);
        chk("m7_clr_rem", int'(remaining), 0);

        // Timeout: no ack, d25 high for exactly 8 cycles, then fault with 25 owed.
        hopper_ack = 1'b0;
        start = 1'b1; amount = 6'd25;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) empty25 = 1'b1;     // tube empties mid-coin: no abort
            chk($sformatf("to_d25_%0d", i), outs(), 6'b100100);
        end
        empty25 = 1'b0;
        tick();
        chk("to_fault_outs", outs(), 6'b000001);
        chk("to_short", int'(shortfall), 25);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("to_clr_outs", outs(), 0);

        // Ack on the 8th DISPENSE cycle wins over expiry.
        start = 1'b1; amount = 6'd25;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("ta_d25_%0d", i), outs(), 6'b100100);
        end
        hopper_ack = 1'b1;
        tick();
        chk("ta_sel_outs", outs(), 6'b000100);
        chk("ta_rem0", int'(remaining), 0);
        tick();
        chk("ta_done_outs", outs(), 6'b000010);
        tick();

        // Asynchronous reset while d10 is high, then pay 5.
        start = 1'b1; amount = 6'd10;
        tick();
        start = 1'b0;
        tick();
        chk("rst_pre_d10", outs(), 6'b010100);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outs", outs(), 0);
        chk("rst_async_rem", int'(remaining), 0);
        #2 reset_n = 1'b1;
        start = 1'b1; amount = 6'd5;
        tick();
        start = 1'b0;
        chk("rst_sel_rem", int'(remaining), 5);
        tick();
        chk("rst_d5_outs", outs(), 6'b001100);
        tick();
        chk("rst_rem0", int'(remaining), 0);
        tick();
        chk("rst_done_outs", outs(), 6'b000010);
        tick();
        chk("rst_idle_outs", outs(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
